// File: rtl/multi_hash_computation.sv
// -----------------------------------------------------------------------------
// multi_hash_computation
//   Computes NUM_HASH independent H3 hashes of one address in parallel.
//   Each row r owns ADDR_SIZE seeds; the hash is the XOR of the seeds whose
//   address bit is set. Stage 0 masks the seeds with the address bits, then
//   LVL registered stages fold adjacent pairs with XOR. A global advance
//   enable gives valid/ready flow control. A tag travels with each address.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready = !out_valid || out_ready)
//   in_addr, in_tag     address to hash, sideband returned unchanged
//   seed_we/row/bit/data  seed table write port (out-of-range ignored)
//   out_valid/out_ready output handshake
//   out_hash            row r in bits [r*HASH_SIZE +: HASH_SIZE]
//   out_tag             tag of the result
//   hash_count          (MULTI_HASH_PERF_CNT_EN only) saturating count of
//                       delivered results
//
// Optional feature macro: MULTI_HASH_PERF_CNT_EN
// -----------------------------------------------------------------------------
module multi_hash_computation #(
  parameter int W         = 4096,
  parameter int HASH_SIZE = $clog2(W),
  parameter int ADDR_SIZE = 22,
  parameter int NUM_HASH  = 4,
  parameter int TAG_SIZE  = 8,
  parameter int LVL       = $clog2(ADDR_SIZE),
  localparam int ROW_W    = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_SIZE-1:0]          in_addr,
  input  logic [TAG_SIZE-1:0]           in_tag,
  input  logic                          seed_we,
  input  logic [ROW_W-1:0]              seed_row,
  input  logic [LVL-1:0]                seed_bit,
  input  logic [HASH_SIZE-1:0]          seed_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_HASH*HASH_SIZE-1:0] out_hash,
  output logic [TAG_SIZE-1:0]           out_tag
`ifdef MULTI_HASH_PERF_CNT_EN
  ,
  output logic [31:0]                   hash_count
`endif
);

  localparam int PAD = 1 << LVL;                 // leaves of the XOR tree
  localparam int RW  = NUM_HASH * HASH_SIZE;     // one element across all rows
  // All stages packed into one vector: stage k has PAD>>k elements per row,
  // so the total element count is 2*PAD-1.
  localparam int TOT = RW * (2 * PAD - 1);

  // Bit offset of stage k inside the packed pipeline vector.
  function automatic int stage_off(input int k);
    return RW * (2 * PAD - ((2 * PAD) >> k));
  endfunction

  logic [HASH_SIZE-1:0] r_seed [NUM_HASH][ADDR_SIZE];
  logic [TOT-1:0]       r_pipe;
  logic [TOT-1:0]       w_pipe;
  logic [LVL:0]         r_valid;
  logic [TAG_SIZE-1:0]  r_tag [LVL+1];
  logic                 w_adv;
  logic                 w_row_ok;
  logic                 w_bit_ok;

  assign w_adv     = !r_valid[LVL] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_valid[LVL];
  assign out_tag   = r_tag[LVL];
  assign out_hash  = r_pipe[stage_off(LVL) +: RW];

  assign w_row_ok = (32'(seed_row) < NUM_HASH);
  assign w_bit_ok = (32'(seed_bit) < ADDR_SIZE);

  // Seed table. Stage 0 reads the registered values, so an input accepted
  // on the same edge as a write still sees the old seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_HASH; r++) begin
        for (int i = 0; i < ADDR_SIZE; i++) begin
          r_seed[r][i] <= '0;
        end
      end
    end else if (seed_we && w_row_ok && w_bit_ok) begin
      r_seed[seed_row][seed_bit] <= seed_data;
    end
  end

  genvar gr, gi, gk;

  // Stage 0 input: mask each seed with its address bit; pad leaves are zero.
  generate
    for (gr = 0; gr < NUM_HASH; gr++) begin : g_leaf_row
      for (gi = 0; gi < PAD; gi++) begin : g_leaf
        if (gi < ADDR_SIZE) begin : g_real
          assign w_pipe[(gr * PAD + gi) * HASH_SIZE +: HASH_SIZE] =
            in_addr[gi] ? r_seed[gr][gi] : '0;
        end else begin : g_pad
          assign w_pipe[(gr * PAD + gi) * HASH_SIZE +: HASH_SIZE] = '0;
        end
      end
    end
  endgenerate

  // Stage k input: XOR adjacent element pairs of stage k-1, row by row.
  generate
    for (gk = 1; gk <= LVL; gk++) begin : g_lvl
      localparam int N     = PAD >> gk;
      localparam int O_CUR = stage_off(gk);
      localparam int O_PRV = stage_off(gk - 1);
      for (gr = 0; gr < NUM_HASH; gr++) begin : g_row
        for (gi = 0; gi < N; gi++) begin : g_pair
          assign w_pipe[O_CUR + (gr * N + gi) * HASH_SIZE +: HASH_SIZE] =
            r_pipe[O_PRV + (gr * 2 * N + 2 * gi) * HASH_SIZE +: HASH_SIZE] ^
            r_pipe[O_PRV + (gr * 2 * N + 2 * gi + 1) * HASH_SIZE +: HASH_SIZE];
        end
      end
    end
  endgenerate

  // Whole pipeline shifts together on advance and freezes otherwise, which
  // keeps the final stage (and thus the outputs) stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe  <= '0;
      r_valid <= '0;
      for (int k = 0; k <= LVL; k++) begin
        r_tag[k] <= '0;
      end
    end else if (w_adv) begin
      r_pipe   <= w_pipe;
      r_valid  <= {r_valid[LVL-1:0], in_valid};
      r_tag[0] <= in_tag;
      for (int k = 1; k <= LVL; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

`ifdef MULTI_HASH_PERF_CNT_EN
  logic [31:0] r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (r_valid[LVL] && out_ready && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end
  assign hash_count = r_count;
`endif

endmodule
